// File: rtl/hicore_trap_ctrl_pkg.sv
// Shared constants and types for the commit-stage trap sequencer.
// Holds the IRQ bit positions, bus widths, sequencer state encoding and trap source record.
package hicore_trap_ctrl_pkg;

  localparam int unsigned HiCore_IRQ_SIZE  = 12;
  localparam int unsigned HiCore_EXCP_SIZE = 16;
  localparam int unsigned HiCore_PC_SIZE   = 32;

  localparam int unsigned IRQ_MSI = 3;
  localparam int unsigned IRQ_MTI = 7;
  localparam int unsigned IRQ_MEI = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_REDIR = 2'd2
  } trap_state_e;

  typedef struct packed {
    logic excp;
    logic irq;
    logic mret;
  } trap_src_t;

endpackage

// File: rtl/gnrl_dff.sv
// Generic reset flops: gnrl_dffr always loads, gnrl_dfflr loads only when lden is high.
// One cycle latency, no backpressure; asynchronous active-low reset to zero.
module gnrl_dffr #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qout <= '0;
    end else begin
      qout <= dnxt;
    end
  end

endmodule

module gnrl_dfflr #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qout <= '0;
    end else if (lden) begin
      qout <= dnxt;
    end
  end

endmodule

// File: rtl/hicore_irq_prio.sv
// Combinational interrupt picker: one-hot winner MEI > MSI > MTI plus its 4-bit cause.
// Zero latency, no backpressure; non-machine-level bits of irq_act are ignored.
module hicore_irq_prio
  import hicore_trap_ctrl_pkg::*;
#(
  parameter int IRQ_SIZE = HiCore_IRQ_SIZE
) (
  input  logic [IRQ_SIZE-1:0] irq_act,
  output logic [IRQ_SIZE-1:0] irq_oh,
  output logic [3:0]          irq_cause,
  output logic                irq_any
);

  logic unused_irq_bits;
  assign unused_irq_bits = ^irq_act;

  always_comb begin
    irq_oh    = '0;
    irq_cause = 4'd0;
    irq_any   = 1'b1;
    if (irq_act[IRQ_MEI]) begin
      irq_oh[IRQ_MEI] = 1'b1;
      irq_cause       = 4'(IRQ_MEI);
    end else if (irq_act[IRQ_MSI]) begin
      irq_oh[IRQ_MSI] = 1'b1;
      irq_cause       = 4'(IRQ_MSI);
    end else if (irq_act[IRQ_MTI]) begin
      irq_oh[IRQ_MTI] = 1'b1;
      irq_cause       = 4'(IRQ_MTI);
    end else begin
      irq_any = 1'b0;
    end
  end

endmodule

// File: rtl/hicore_trap_ctrl.sv
// Commit-stage trap sequencer: injects irqs on commit, then flushes and redirects fetch on trap/mret.
// Trigger at T: flush T+1..T+FLUSH_CYC, redir_vld from T+FLUSH_CYC+1; commits stall until redir_rdy.
module hicore_trap_ctrl
  import hicore_trap_ctrl_pkg::*;
#(
  parameter int IRQ_SIZE  = HiCore_IRQ_SIZE,
  parameter int EXCP_SIZE = HiCore_EXCP_SIZE,
  parameter int PC_SIZE   = HiCore_PC_SIZE,
  parameter int FLUSH_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 commit_valid,
  input  logic [EXCP_SIZE-1:0] commit_excp,
  input  logic                 commit_mret_op,
  input  logic [PC_SIZE-1:0]   commit_next_pc,
  input  logic [IRQ_SIZE-1:0]  irq_pend,
  input  logic [IRQ_SIZE-1:0]  irq_msk,
  input  logic [PC_SIZE-1:0]   csr_mtvec,
  input  logic [PC_SIZE-1:0]   csr_mepc,
  output logic [IRQ_SIZE-1:0]  commit_irq,
  output logic                 commit_stall,
  output logic                 flush,
  output logic                 redir_vld,
  input  logic                 redir_rdy,
  output logic [PC_SIZE-1:0]   redir_pc
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYC - 1);

  logic [1:0]          state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                flush_q, flush_d;
  logic                stall_q, stall_d;
  logic                redir_vld_q, redir_vld_d;
  logic [PC_SIZE-1:0]  redir_pc_q, trap_tgt;

  logic [IRQ_SIZE-1:0] irq_act, irq_oh;
  logic [3:0]          irq_cause;
  logic                irq_any;
  logic                eval, trigger;
  trap_src_t           src;
  logic [PC_SIZE-1:0]  vec_base, vec_off;

  // The next-PC of the head is not needed: every target comes from mtvec or mepc.
  logic unused_next_pc;
  assign unused_next_pc = ^commit_next_pc;

  assign irq_act = irq_pend & irq_msk;

  hicore_irq_prio #(
    .IRQ_SIZE (IRQ_SIZE)
  ) u_irq_prio (
    .irq_act   (irq_act),
    .irq_oh    (irq_oh),
    .irq_cause (irq_cause),
    .irq_any   (irq_any)
  );

  always_comb begin
    eval     = commit_valid && (state_q == ST_IDLE);
    src.excp = eval && (|commit_excp);
    src.irq  = eval && !(|commit_excp) && irq_any;
    src.mret = eval && !(|commit_excp) && !irq_any && commit_mret_op;
    trigger  = |src;

    commit_irq = src.irq ? irq_oh : '0;

    vec_base = {csr_mtvec[PC_SIZE-1:2], 2'b00};
    vec_off  = {{(PC_SIZE-6){1'b0}}, irq_cause, 2'b00};
    if (src.excp) begin
      trap_tgt = vec_base;
    end else if (src.irq) begin
      trap_tgt = (csr_mtvec[1:0] == 2'b01) ? (vec_base + vec_off) : vec_base;
    end else begin
      trap_tgt = csr_mepc;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          state_d = ST_FLUSH;
          cnt_d   = FLUSH_LOAD;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_REDIR;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_REDIR: begin
        if (redir_rdy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they leave the flops glitch-free.
    flush_d     = (state_d == ST_FLUSH);
    redir_vld_d = (state_d == ST_REDIR);
    stall_d     = flush_d || redir_vld_d;
  end

  gnrl_dffr  #(.DW(2))       u_state_dff (.clk(clk), .rst_n(rst_n), .dnxt(state_d),     .qout(state_q));
  gnrl_dffr  #(.DW(4))       u_cnt_dff   (.clk(clk), .rst_n(rst_n), .dnxt(cnt_d),       .qout(cnt_q));
  gnrl_dffr  #(.DW(1))       u_flush_dff (.clk(clk), .rst_n(rst_n), .dnxt(flush_d),     .qout(flush_q));
  gnrl_dffr  #(.DW(1))       u_stall_dff (.clk(clk), .rst_n(rst_n), .dnxt(stall_d),     .qout(stall_q));
  gnrl_dffr  #(.DW(1))       u_rvld_dff  (.clk(clk), .rst_n(rst_n), .dnxt(redir_vld_d), .qout(redir_vld_q));
  gnrl_dfflr #(.DW(PC_SIZE)) u_rpc_dff   (.clk(clk), .rst_n(rst_n), .lden(trigger),
                                          .dnxt(trap_tgt), .qout(redir_pc_q));

  assign flush        = flush_q;
  assign commit_stall = stall_q;
  assign redir_vld    = redir_vld_q;
  assign redir_pc     = redir_pc_q;

endmodule

// File: tb/tb_hicore_trap_ctrl.sv
// Bench for hicore_trap_ctrl: timeline model checked every cycle plus directed literal checks.
module tb_hicore_trap_ctrl;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        commit_valid = 1'b0;
  logic [15:0] commit_excp = '0;
  logic        commit_mret_op = 1'b0;
  logic [31:0] commit_next_pc = '0;
  logic [11:0] irq_pend = '0;
  logic [11:0] irq_msk = '0;
  logic [31:0] csr_mtvec = '0;
  logic [31:0] csr_mepc = '0;
  logic [11:0] commit_irq;
  logic        commit_stall;
  logic        flush;
  logic        redir_vld;
  logic        redir_rdy = 1'b0;
  logic [31:0] redir_pc;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  hicore_trap_ctrl #(
    .FLUSH_CYC (FC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .commit_valid   (commit_valid),
    .commit_excp    (commit_excp),
    .commit_mret_op (commit_mret_op),
    .commit_next_pc (commit_next_pc),
    .irq_pend       (irq_pend),
    .irq_msk        (irq_msk),
    .csr_mtvec      (csr_mtvec),
    .csr_mepc       (csr_mepc),
    .commit_irq     (commit_irq),
    .commit_stall   (commit_stall),
    .flush          (flush),
    .redir_vld      (redir_vld),
    .redir_rdy      (redir_rdy),
    .redir_pc       (redir_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Machine interrupt winner by name: external, then software, then timer.
  function automatic logic [11:0] win(input logic [11:0] a);
    if (a[11]) return 12'h800;
    if (a[3])  return 12'h008;
    if (a[7])  return 12'h080;
    return 12'h000;
  endfunction

  function automatic int cause_of(input logic [11:0] oh);
    if (oh == 12'h800) return 11;
    if (oh == 12'h008) return 3;
    return 7;
  endfunction

  // Model: a trap sequence is a time window measured from the trigger cycle.
  bit          m_act = 1'b0;
  int          m_cyc = 0;
  int          m_t = 0;
  logic [31:0] m_pc = '0;
  logic [11:0] m_w;
  logic [31:0] m_base;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 1'b0;
      m_pc  = '0;
    end else begin
      if (m_act) begin
        if ((m_cyc - m_t) >= FC + 1 && redir_rdy) m_act = 1'b0;
      end else if (commit_valid) begin
        m_w    = win(irq_pend & irq_msk);
        m_base = csr_mtvec & 32'hFFFF_FFFC;
        if (|commit_excp) begin
          m_act = 1'b1; m_t = m_cyc; m_pc = m_base;
        end else if (m_w != 12'h000) begin
          m_act = 1'b1; m_t = m_cyc;
          m_pc  = (csr_mtvec[1:0] == 2'b01) ? m_base + 32'(4 * cause_of(m_w)) : m_base;
        end else if (commit_mret_op) begin
          m_act = 1'b1; m_t = m_cyc; m_pc = csr_mepc;
        end
      end
      m_cyc++;
    end
  end

  logic [11:0] e_irq;
  logic        e_flush, e_vld;

  always @(negedge clk) begin
    if (chk_en) begin
      e_irq   = (!m_act && commit_valid && !(|commit_excp)) ? win(irq_pend & irq_msk) : 12'h000;
      e_flush = m_act && (m_cyc - m_t) >= 1 && (m_cyc - m_t) <= FC;
      e_vld   = m_act && (m_cyc - m_t) >= FC + 1;
      chk("cyc_commit_irq", 32'(commit_irq), 32'(e_irq));
      chk("cyc_flush", 32'(flush), 32'(e_flush));
      chk("cyc_redir_vld", 32'(redir_vld), 32'(e_vld));
      chk("cyc_stall", 32'(commit_stall), 32'(m_act));
      chk("cyc_redir_pc", redir_pc, m_pc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_redir(input string nm);
    for (int k = 0; k < 20 && !redir_vld; k++) tick();
    chk({nm, "_redir_timeout"}, 32'(redir_vld), 32'd1);
  endtask

  task automatic handshake(input string nm);
    redir_rdy = 1'b1;
    tick();
    redir_rdy = 1'b0;
    chk({nm, "_resume"}, 32'(commit_stall), 32'd0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    #2;
    chk("rst_outputs", 32'({commit_irq, commit_stall, flush, redir_vld}), 32'd0);
    chk("rst_redir_pc", redir_pc, 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t1_idle", 32'({commit_irq, commit_stall, flush, redir_vld}), 32'd0);
    end

    // Exception through mtvec base, full sequence timing.
    csr_mtvec = 32'h100; commit_valid = 1'b1; commit_excp = 16'h0004;
    #1 chk("t2_irq_zero", 32'(commit_irq), 32'd0);
    tick(); commit_valid = 1'b0; commit_excp = '0;
    chk("t2_flush1", 32'(flush), 32'd1);
    tick();
    chk("t2_flush2", 32'(flush), 32'd1);
    chk("t2_no_vld_yet", 32'(redir_vld), 32'd0);
    tick();
    chk("t2_flush_done", 32'(flush), 32'd0);
    chk("t2_vld", 32'(redir_vld), 32'd1);
    chk("t2_pc", redir_pc, 32'h100);
    handshake("t2");

    // Vectored external interrupt.
    csr_mtvec = 32'h101; irq_pend = 12'h888; irq_msk = 12'h888; commit_valid = 1'b1;
    #1 chk("t3_irq", 32'(commit_irq), 32'h800);
    tick();
    #1 chk("t3_irq_busy", 32'(commit_irq), 32'd0);
    commit_valid = 1'b0;
    wait_redir("t3");
    chk("t3_pc", redir_pc, 32'h12C);
    handshake("t3");
    irq_msk = '0; commit_valid = 1'b1;
    #1 chk("t3_masked_irq", 32'(commit_irq), 32'd0);
    tick(); commit_valid = 1'b0;
    chk("t3_masked_noflush", 32'(flush), 32'd0);
    irq_pend = '0;

    // mret competing with a timer interrupt, then alone.
    csr_mtvec = 32'h100; csr_mepc = 32'h2000; commit_mret_op = 1'b1;
    irq_pend = 12'h080; irq_msk = 12'h080; commit_valid = 1'b1;
    #1 chk("t4_irq_wins", 32'(commit_irq), 32'h080);
    tick(); commit_valid = 1'b0; commit_mret_op = 1'b0;
    wait_redir("t4a");
    chk("t4_pc_trap", redir_pc, 32'h100);
    handshake("t4a");
    irq_msk = '0; commit_mret_op = 1'b1; commit_valid = 1'b1;
    #1 chk("t4_mret_irq", 32'(commit_irq), 32'd0);
    tick(); commit_valid = 1'b0; commit_mret_op = 1'b0;
    wait_redir("t4b");
    chk("t4_pc_mepc", redir_pc, 32'h2000);
    handshake("t4b");
    irq_pend = '0;

    // Early redir_rdy ignored, REDIR held, interrupt deferred to IDLE.
    commit_excp = 16'h0001; commit_valid = 1'b1;
    tick(); commit_excp = '0; commit_valid = 1'b0; redir_rdy = 1'b1;
    tick();
    chk("t5_early_rdy_flush", 32'(flush), 32'd1);
    redir_rdy = 1'b0;
    tick();
    irq_pend = 12'h800; irq_msk = 12'h800; commit_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_vld", 32'(redir_vld), 32'd1);
      chk("t5_hold_stall", 32'(commit_stall), 32'd1);
      chk("t5_hold_pc", redir_pc, 32'h100);
      chk("t5_hold_irq", 32'(commit_irq), 32'd0);
      tick();
    end
    commit_valid = 1'b0;
    handshake("t5a");
    commit_valid = 1'b1;
    #1 chk("t5_irq_later", 32'(commit_irq), 32'h800);
    tick(); commit_valid = 1'b0;
    wait_redir("t5b");
    chk("t5_pc", redir_pc, 32'h100);
    handshake("t5b");
    irq_pend = '0; irq_msk = '0;

    // Reset pulse in the middle of FLUSH.
    csr_mtvec = 32'h340; commit_excp = 16'h0002; commit_valid = 1'b1;
    tick(); commit_excp = '0; commit_valid = 1'b0;
    chk("t6_flush_before", 32'(flush), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_flush", 32'(flush), 32'd0);
    chk("t6_async_stall", 32'(commit_stall), 32'd0);
    chk("t6_async_pc", redir_pc, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t6_no_redir", 32'(redir_vld), 32'd0);
    end

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
